// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings, opcodes,
// datapath mux codes and the control word handed from the decoder to the FSM top.
package multicycle_control_fsm_pkg;

  localparam int unsigned OpW = 6;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExec     = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StIExec    = 4'd9,
    StIWb      = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [OpW-1:0] OpRType = 6'h00;
  localparam logic [OpW-1:0] OpLw    = 6'h23;
  localparam logic [OpW-1:0] OpSw    = 6'h2B;
  localparam logic [OpW-1:0] OpBeq   = 6'h04;
  localparam logic [OpW-1:0] OpBne   = 6'h05;
  localparam logic [OpW-1:0] OpAddi  = 6'h08;
  localparam logic [OpW-1:0] OpOri   = 6'h0D;
  localparam logic [OpW-1:0] OpJ     = 6'h02;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;
  localparam logic [1:0] AluOpOr    = 2'b11;

  localparam logic [1:0] AluSrcBReg    = 2'b00;
  localparam logic [1:0] AluSrcBFour   = 2'b01;
  localparam logic [1:0] AluSrcBImm    = 2'b10;
  localparam logic [1:0] AluSrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_word_t;

  function automatic logic opcode_legal(logic [OpW-1:0] op);
    case (op)
      OpRType, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpOri, OpJ: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_decoder.sv
// Combinational state -> control word decode. Only BRANCH and IEXEC look at the latched
// opcode; everything else is a pure Moore decode of the state.
module multicycle_control_fsm_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  state_e           state_i,
  input  logic [OpW-1:0]   opcode_i,
  output ctrl_word_t       ctrl_o
);

  // Per-state control word; unlisted fields stay 0 except ext_op which defaults to 1.
  always_comb begin
    ctrl_o        = '0;
    ctrl_o.ext_op = 1'b1;
    case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = AluSrcBFour;
        ctrl_o.alu_op    = AluOpAdd;
        ctrl_o.pc_src    = PcSrcAlu;
      end
      StDecode: begin
        ctrl_o.alu_src_b = AluSrcBImmSh2;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemAdr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = AluSrcBImm;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemRead: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      StMemWrite: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      StExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = AluSrcBReg;
        ctrl_o.alu_op    = AluOpFunct;
      end
      StAluWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = AluSrcBReg;
        ctrl_o.alu_op    = AluOpSub;
        ctrl_o.pc_src    = PcSrcAluOut;
        ctrl_o.branch    = (opcode_i == OpBeq);
        ctrl_o.branch_ne = (opcode_i == OpBne);
      end
      StIExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = AluSrcBImm;
        if (opcode_i == OpOri) begin
          ctrl_o.ext_op = 1'b0;
          ctrl_o.alu_op = AluOpOr;
        end else begin
          ctrl_o.alu_op = AluOpAdd;
        end
      end
      StIWb: begin
        ctrl_o.reg_write = 1'b1;
      end
      StJump: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PcSrcJump;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control: state and opcode registers, next-state logic, and the
// strobe gating (Mem_Ready in FETCH, branch condition, reset override).
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                Mem_Ready,
  output logic                PC_Enable,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                ExtOp,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSrc,
  output logic                Illegal_Opcode,
  output logic [STATE_W-1:0]  State
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [OpW-1:0]      op_in, op_lat;
  ctrl_word_t          ctrl;
  logic                fetch_gate;

  assign op_in  = OpW'(Opcode);
  assign op_lat = OpW'(opcode_q);

  // Next state; the opcode is captured in DECODE and later states only see the copy.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      StFetch:    if (Mem_Ready) state_d = StDecode;
      StDecode: begin
        opcode_d = Opcode;
        case (op_in)
          OpLw, OpSw:    state_d = StMemAdr;
          OpRType:       state_d = StExec;
          OpBeq, OpBne:  state_d = StBranch;
          OpAddi, OpOri: state_d = StIExec;
          OpJ:           state_d = StJump;
          default:       state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op_lat == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  if (Mem_Ready) state_d = StMemWb;
      StMemWrite: if (Mem_Ready) state_d = StFetch;
      StExec:     state_d = StAluWb;
      StIExec:    state_d = StIWb;
      StMemWb, StAluWb, StBranch, StIWb, StJump: state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // State and opcode registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  multicycle_control_fsm_decoder u_decoder (
    .state_i  (state_q),
    .opcode_i (op_lat),
    .ctrl_o   (ctrl)
  );

  // In FETCH the PC and IR only load once memory has returned the instruction.
  assign fetch_gate = (state_q == StFetch) ? Mem_Ready : 1'b1;

  // Strobes are forced low while reset is held so an in-flight access is abandoned.
  assign PC_Enable      = ~reset & ((ctrl.pc_write & fetch_gate) | (ctrl.branch & Zero) |
                                    (ctrl.branch_ne & ~Zero));
  assign IRWrite        = ~reset & ctrl.ir_write & Mem_Ready;
  assign MemRead        = ~reset & ctrl.mem_read;
  assign MemWrite       = ~reset & ctrl.mem_write;
  assign RegWrite       = ~reset & ctrl.reg_write;
  assign Illegal_Opcode = ~reset & (state_q == StDecode) & ~opcode_legal(op_in);

  assign IorD     = ctrl.iord;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ExtOp    = ctrl.ext_op;
  assign ALUOp    = ctrl.alu_op;
  assign PCSrc    = ctrl.pc_src;
  assign State    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle control FSM: walks each instruction class through its
// state path and checks the control outputs against hand-derived values.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       Zero;
  logic       Mem_Ready;
  logic       PC_Enable, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, ExtOp, Illegal_Opcode;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] State;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk            (clk),
    .reset          (reset),
    .Opcode         (Opcode),
    .Zero           (Zero),
    .Mem_Ready      (Mem_Ready),
    .PC_Enable      (PC_Enable),
    .IorD           (IorD),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .IRWrite        (IRWrite),
    .RegDst         (RegDst),
    .MemtoReg       (MemtoReg),
    .RegWrite       (RegWrite),
    .ALUSrcA        (ALUSrcA),
    .ALUSrcB        (ALUSrcB),
    .ExtOp          (ExtOp),
    .ALUOp          (ALUOp),
    .PCSrc          (PCSrc),
    .Illegal_Opcode (Illegal_Opcode),
    .State          (State)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then let inputs/outputs settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; Opcode = 6'h00; Zero = 1'b0; Mem_Ready = 1'b1;
    settle();
    check_eq("rst_pcen", PC_Enable, 0);
    check_eq("rst_memrd", MemRead, 0);
    check_eq("rst_irw", IRWrite, 0);
    tick();
    check_eq("rst_state", State, 0);
    tick();
    reset = 1'b0;

    // lw with memory always ready; Opcode changed after DECODE to prove the latch is used.
    Opcode = 6'h23; settle();
    check_eq("lw_f_state", State, 0);
    check_eq("lw_f_irw", IRWrite, 1);
    check_eq("lw_f_pcen", PC_Enable, 1);
    check_eq("lw_f_memrd", MemRead, 1);
    check_eq("lw_f_srcb", ALUSrcB, 2'b01);
    check_eq("lw_f_iord", IorD, 0);
    tick();
    check_eq("lw_d_state", State, 1);
    check_eq("lw_d_srcb", ALUSrcB, 2'b11);
    check_eq("lw_d_ill", Illegal_Opcode, 0);
    tick();
    Opcode = 6'h2B; settle();
    check_eq("lw_ma_state", State, 2);
    check_eq("lw_ma_srca", ALUSrcA, 1);
    check_eq("lw_ma_srcb", ALUSrcB, 2'b10);
    check_eq("lw_ma_regw", RegWrite, 0);
    tick();
    check_eq("lw_mr_state", State, 3);
    check_eq("lw_mr_memrd", MemRead, 1);
    check_eq("lw_mr_iord", IorD, 1);
    check_eq("lw_mr_regw", RegWrite, 0);
    tick();
    check_eq("lw_wb_state", State, 4);
    check_eq("lw_wb_regw", RegWrite, 1);
    check_eq("lw_wb_m2r", MemtoReg, 1);
    check_eq("lw_wb_rdst", RegDst, 0);
    tick();
    check_eq("lw_done_state", State, 0);

    // FETCH stall for three cycles, then beq.
    Mem_Ready = 1'b0; Opcode = 6'h04;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("stall_state", State, 0);
      check_eq("stall_irw", IRWrite, 0);
      check_eq("stall_pcen", PC_Enable, 0);
      check_eq("stall_memrd", MemRead, 1);
      tick();
    end
    Mem_Ready = 1'b1; settle();
    check_eq("stall_rdy_irw", IRWrite, 1);
    check_eq("stall_rdy_pcen", PC_Enable, 1);
    tick();
    check_eq("beq_d_state", State, 1);
    tick();
    Zero = 1'b1; settle();
    check_eq("beq_b_state", State, 8);
    check_eq("beq_z1_pcen", PC_Enable, 1);
    check_eq("beq_b_pcsrc", PCSrc, 2'b01);
    check_eq("beq_b_aluop", ALUOp, 2'b01);
    Zero = 1'b0; settle();
    check_eq("beq_z0_pcen", PC_Enable, 0);
    tick();
    check_eq("beq_done_state", State, 0);

    // bne
    Opcode = 6'h05; tick(); tick();
    Zero = 1'b1; settle();
    check_eq("bne_b_state", State, 8);
    check_eq("bne_z1_pcen", PC_Enable, 0);
    Zero = 1'b0; settle();
    check_eq("bne_z0_pcen", PC_Enable, 1);
    tick();

    // ori
    Opcode = 6'h0D; tick(); tick();
    check_eq("ori_ie_state", State, 9);
    check_eq("ori_ie_ext", ExtOp, 0);
    check_eq("ori_ie_aluop", ALUOp, 2'b11);
    check_eq("ori_ie_srcb", ALUSrcB, 2'b10);
    tick();
    check_eq("ori_wb_state", State, 10);
    check_eq("ori_wb_regw", RegWrite, 1);
    check_eq("ori_wb_rdst", RegDst, 0);
    check_eq("ori_wb_m2r", MemtoReg, 0);
    tick();

    // addi
    Opcode = 6'h08; tick(); tick();
    check_eq("addi_ie_ext", ExtOp, 1);
    check_eq("addi_ie_aluop", ALUOp, 2'b00);
    tick(); tick();

    // R-type
    Opcode = 6'h00; tick(); tick();
    check_eq("r_ex_state", State, 6);
    check_eq("r_ex_aluop", ALUOp, 2'b10);
    check_eq("r_ex_srcb", ALUSrcB, 2'b00);
    tick();
    check_eq("r_wb_state", State, 7);
    check_eq("r_wb_regw", RegWrite, 1);
    check_eq("r_wb_rdst", RegDst, 1);
    tick();

    // j
    Opcode = 6'h02; tick(); tick();
    check_eq("j_state", State, 11);
    check_eq("j_pcen", PC_Enable, 1);
    check_eq("j_pcsrc", PCSrc, 2'b10);
    tick();
    check_eq("j_done_state", State, 0);

    // illegal opcode
    Opcode = 6'h3F; tick();
    check_eq("ill_d_state", State, 1);
    check_eq("ill_d_pulse", Illegal_Opcode, 1);
    check_eq("ill_d_regw", RegWrite, 0);
    check_eq("ill_d_memw", MemWrite, 0);
    tick();
    check_eq("ill_next_state", State, 0);
    check_eq("ill_next_pulse", Illegal_Opcode, 0);

    // sw stalled in MEMWRITE, then reset abandons it.
    Opcode = 6'h2B; tick(); tick(); tick();
    Mem_Ready = 1'b0; settle();
    check_eq("sw_mw_state", State, 5);
    check_eq("sw_mw_memw", MemWrite, 1);
    check_eq("sw_mw_iord", IorD, 1);
    tick();
    check_eq("sw_stall_state", State, 5);
    reset = 1'b1; settle();
    check_eq("sw_rst_memw", MemWrite, 0);
    tick();
    check_eq("sw_rst_state", State, 0);
    reset = 1'b0; settle();
    check_eq("sw_after_memw", MemWrite, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
